// File: rtl/seq_alu.sv
// seq_alu: registered ALU, single-cycle ops plus iterative MUL/DIV.
// Define SEQ_ALU_SIGNED_MULDIV_EN for two's-complement MUL/DIV.

module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   RA,
  input  logic [WIDTH-1:0]   RB,
  output logic [2*WIDTH-1:0] RC,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

`ifdef SEQ_ALU_SIGNED_MULDIV_EN
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic [2*WIDTH-1:0] r_rc;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opd;
  logic               r_is_div;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_div0;
  logic               w_multi;
  logic               w_last;
  logic [WIDTH-1:0]   w_lo;
  logic [SHAMT_W-1:0] w_sh;
  logic [SHAMT_W-1:0] w_rsh_amt;
  logic [SHAMT_W-1:0] w_lsh_amt;
  logic [WIDTH-1:0]   w_rot;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_hi_nx;
  logic [WIDTH-1:0]   w_lo_nx;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_is_mul = (opcode == OP_MUL);
  assign w_is_div = (opcode == OP_DIV);
  assign w_div0   = w_is_div && (RB == '0);
  assign w_multi  = w_is_mul || (w_is_div && !w_div0);
  assign w_last   = (r_cnt == CW'(1));

`ifdef SEQ_ALU_SIGNED_MULDIV_EN
  logic               r_neg_hi;
  logic               r_neg_lo;
  logic [2*WIDTH-1:0] w_fix;
  logic [2*WIDTH-1:0] w_prod;

  assign w_a_mag = RA[WIDTH-1] ? -RA : RA;
  assign w_b_mag = RB[WIDTH-1] ? -RB : RB;

  // Sign correction applied to the magnitude result after ITER
  always_comb begin
    w_prod = {r_hi, r_lo};
    w_fix  = w_prod;
    if (r_is_div) begin
      w_fix[2*WIDTH-1:WIDTH] = r_neg_hi ? -r_hi : r_hi;
      w_fix[WIDTH-1:0]       = r_neg_lo ? -r_lo : r_lo;
    end else if (r_neg_lo) begin
      w_fix = -w_prod;
    end
  end

  assign busy = (r_state == ITER) || (r_state == FIX);
`else
  assign w_a_mag = RA;
  assign w_b_mag = RB;
  assign busy    = (r_state == ITER);
`endif

  assign done     = (r_state == DONE);
  assign RC       = r_rc;
  assign div_zero = r_div_zero;

  // Single-cycle result; rol is a right-rotate by the negated amount
  always_comb begin
    w_sh      = RB[SHAMT_W-1:0];
    w_rsh_amt = (opcode == OP_ROL) ? -w_sh : w_sh;
    w_lsh_amt = -w_rsh_amt;
    w_rot     = (RA >> w_rsh_amt) | (RA << w_lsh_amt);
    w_lo      = '0;
    case (opcode)
      OP_ADD, OP_ADDI: w_lo = RA + RB;
      OP_SUB:          w_lo = RA - RB;
      OP_SHR:          w_lo = RA >> w_sh;
      OP_SHL:          w_lo = RA << w_sh;
      OP_ROR, OP_ROL:  w_lo = w_rot;
      OP_AND, OP_ANDI: w_lo = RA & RB;
      OP_OR, OP_ORI:   w_lo = RA | RB;
      OP_NEG:          w_lo = '0 - RA;
      OP_NOT:          w_lo = ~RB;
      default:         w_lo = '0;
    endcase
  end

  // One shift-add or restoring-subtract step on the HI/LO pair
  always_comb begin
    w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    w_rsh  = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_rsh - {1'b0, r_opd};
    if (r_is_div) begin
      w_hi_nx = w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      w_hi_nx = w_msum[WIDTH:1];
      w_lo_nx = {w_msum[0], r_lo[WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; DONE accepts a new op just like IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = w_multi ? ITER : DONE;
        else          w_next = IDLE;
      end
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
      ITER:    if (w_last) w_next = FIX;
      FIX:     w_next = DONE;
`else
      ITER:    if (w_last) w_next = DONE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, iteration registers, result and div_zero flag
  always_ff @(posedge clk) begin
    if (clear) begin
      r_rc       <= '0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opd      <= '0;
      r_is_div   <= 1'b0;
      r_cnt      <= '0;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
      r_neg_hi   <= 1'b0;
      r_neg_lo   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_div_zero <= w_div0;
      if (w_multi) begin
        r_is_div <= w_is_div;
        r_cnt    <= CW'(WIDTH);
        r_hi     <= '0;
        r_lo     <= w_is_div ? w_a_mag : w_b_mag;
        r_opd    <= w_is_div ? w_b_mag : w_a_mag;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        r_neg_hi <= RA[WIDTH-1];
        r_neg_lo <= RA[WIDTH-1] ^ RB[WIDTH-1];
`endif
      end else if (w_div0) begin
        r_rc <= {RA, {WIDTH{1'b1}}};
      end else begin
        r_rc <= {{WIDTH{1'b0}}, w_lo};
      end
    end else if (r_state == ITER) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt - CW'(1);
`ifndef SEQ_ALU_SIGNED_MULDIV_EN
      if (w_last) r_rc <= {w_hi_nx, w_lo_nx};
`endif
    end
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    else if (r_state == FIX) begin
      r_rc <= w_fix;
    end
`endif
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed + random checks of seq_alu
// against an arithmetic reference model.

module tb_seq_alu;

  localparam int W = 32;

`ifdef SEQ_ALU_SIGNED_MULDIV_EN
  localparam int MD_LAT = W + 2;
`else
  localparam int MD_LAT = W + 1;
`endif

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BAD  = 5'b11110;

  logic           clk = 1'b0;
  logic           clear;
  logic           start;
  logic [4:0]     opcode;
  logic [W-1:0]   RA;
  logic [W-1:0]   RB;
  logic [2*W-1:0] RC;
  logic           busy;
  logic           done;
  logic           div_zero;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] last_rc;

  logic [4:0] op_tab [0:15] = '{
    OP_ADD, OP_ADDI, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND,
    OP_ANDI, OP_OR, OP_ORI, OP_NEG, OP_NOT, OP_MUL, OP_DIV, OP_BAD
  };

  seq_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .opcode   (opcode),
    .RA       (RA),
    .RB       (RB),
    .RC       (RC),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [4:0] op,
                                input logic [31:0] a, b,
                                output logic [63:0] rc,
                                output int lat,
                                output logic dz);
    int unsigned s;
    logic [31:0] lo;
    int sa, sb;
    s   = b[4:0];
    lat = 1;
    dz  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: lo = a + b;
      OP_SUB:          lo = a - b;
      OP_SHR:          lo = a >> s;
      OP_SHL:          lo = a << s;
      OP_ROR:          lo = (a >> s) | (a << (32 - s));
      OP_ROL:          lo = (a << s) | (a >> (32 - s));
      OP_AND, OP_ANDI: lo = a & b;
      OP_OR, OP_ORI:   lo = a | b;
      OP_NEG:          lo = 32'd0 - a;
      OP_NOT:          lo = ~b;
      default:         lo = 32'd0;
    endcase
    rc = {32'd0, lo};
    sa = a;
    sb = b;
    if (op == OP_MUL) begin
      lat = MD_LAT;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
      rc = longint'(sa) * longint'(sb);
`else
      rc = {32'd0, a} * {32'd0, b};
`endif
    end
    if (op == OP_DIV) begin
      if (b == 32'd0) begin
        rc = {a, 32'hFFFF_FFFF};
        dz = 1'b1;
      end else begin
        lat = MD_LAT;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          rc = {32'd0, 32'h8000_0000};
        else
          rc = {32'(sa % sb), 32'(sa / sb)};
`else
        rc = {a % b, a / b};
`endif
      end
    end
  endfunction

  // Issue one op at a negedge, wait (bounded) for done, check it all.
  // pulse_at > 0 raises start with an add at that cycle of the wait.
  task automatic do_op(input string tag, input logic [4:0] op,
                       input logic [31:0] a, b, input int pulse_at);
    logic [63:0] erc;
    int elat, lat, nb;
    logic edz;
    model(op, a, b, erc, elat, edz);
    last_rc = erc;
    start  = 1'b1;
    opcode = op;
    RA     = a;
    RB     = b;
    @(posedge clk);
    lat = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      lat++;
      start  = (lat == pulse_at);
      opcode = (lat == pulse_at) ? OP_ADD : 5'($urandom);
      RA     = $urandom;
      RB     = $urandom;
      if (busy) nb++;
    end while (!done && lat < 80);
    start = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".rc"}, RC, erc);
    chk({tag, ".div_zero"}, 64'(div_zero), 64'(edz));
    chk({tag, ".busy_cycles"}, 64'(nb), 64'(elat - 1));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".rc_hold"}, RC, last_rc);
  endtask

  initial begin
    int nd;
    logic [4:0] op;
    logic [31:0] a, b;

    clear  = 1'b1;
    start  = 1'b0;
    opcode = '0;
    RA     = '0;
    RB     = '0;
    repeat (3) @(negedge clk);
    chk("reset.rc", RC, 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.div_zero", 64'(div_zero), 64'd0);
    clear = 1'b0;
    @(negedge clk);

    do_op("add", OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    chk("add.const", RC, 64'h0000_0000_8000_0000);
    idle_chk("add");

    do_op("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, 0);
    idle_chk("mul");

    do_op("div", OP_DIV, 32'd100, 32'd7, 0);
    do_op("div0", OP_DIV, 32'd5, 32'd0, 0);
    do_op("add_clr", OP_ADD, 32'd3, 32'd4, 0);

    do_op("ror", OP_ROR, 32'h0000_0001, 32'd1, 0);
    chk("ror.const", RC, 64'h0000_0000_8000_0000);
    do_op("shl", OP_SHL, 32'd1, 32'd33, 0);
    chk("shl.const", RC, 64'd2);
    do_op("not", OP_NOT, 32'h1234_5678, 32'd0, 0);
    chk("not.const", RC, 64'h0000_0000_FFFF_FFFF);
    do_op("rol", OP_ROL, 32'h8000_0001, 32'd1, 0);
    chk("rol.const", RC, 64'h0000_0000_0000_0003);

    do_op("mul_pulse", OP_MUL, 32'hDEAD_BEEF, 32'h0001_2345, 5);
    do_op("sub_b2b", OP_SUB, 32'd10, 32'd20, 0);
    idle_chk("sub_b2b");

    do_op("bad_op", OP_BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);

    start  = 1'b1;
    opcode = OP_DIV;
    RA     = 32'd1000;
    RB     = 32'd3;
    @(posedge clk);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = 1'b0;
      RA    = $urandom;
    end
    chk("abort.busy_before", 64'(busy), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    chk("abort.rc", RC, 64'd0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    clear = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort.no_done", 64'(nd), 64'd0);
    do_op("div_after", OP_DIV, 32'd1000, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      op = op_tab[$urandom_range(0, 15)];
      a  = $urandom;
      b  = $urandom;
      if (op == OP_DIV && $urandom_range(0, 3) == 0) b = 32'd0;
      if (op == OP_DIV && $urandom_range(0, 3) == 0) b = b >> 20;
      do_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, 0);
      if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the CPU datapath ALU.
- Single-cycle ops (add/sub/logic/shift/rotate/neg/not/immediate forms) complete in one cycle.
- MUL and DIV run as iterative multi-cycle engines (shift-add, restoring divide) behind a start/busy/done handshake.
- Sits between the RA/RB operand registers and the Z (HI/LO) register pair; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand width; result RC is 2*WIDTH.
- SHAMT_W, 5, shift/rotate amount bits taken from RB; must equal log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- clear  in  1  reset, synchronous, active-high.
- start  in  1  request; operands and opcode sampled on the accepting edge.
- opcode  in  5  operation select; encodings below.
- RA  in  WIDTH  operand A.
- RB  in  WIDTH  operand B / immediate.
- RC  out  2*WIDTH  registered result; [2W-1:W]=HI, [W-1:0]=LO.
- busy  out  1  high while MUL/DIV is iterating.
- done  out  1  one-cycle pulse when RC is updated.
- div_zero  out  1  sticky-until-next-start flag; set by DIV with RB==0.

Behaviour:
- Opcodes and results:
  - add 00011, addi 01011: LO = RA+RB.
  - sub 00100: LO = RA-RB.
  - shr 00101: LO = RA>>RB[SHAMT_W-1:0], logical.
  - shl 00110: LO = RA<<RB[SHAMT_W-1:0].
  - ror 00111 / rol 01000: rotate RA by RB[SHAMT_W-1:0].
  - and 01001, andi 01100: LO = RA&RB. or 01010, ori 01101: LO = RA|RB.
  - neg 10000: LO = 0-RA. not 10001: LO = ~RB.
  - mul 01110: RC = full 2W product.
  - div 01111: LO = quotient, HI = remainder.
- HI=0 for every non-MUL/DIV op. Arithmetic wraps modulo 2^W; no carry/overflow output.
- Unrecognised opcode: RC=0, completes as a single-cycle op.
- Reset (clear=1 at an edge): state=IDLE, RC=0, busy=0, done=0, div_zero=0.
- FSM states: IDLE, ITER, DONE.
  - IDLE: on start, a single-cycle op writes RC and goes to DONE. MUL/DIV latch operands, load counter = WIDTH, go to ITER, busy=1.
  - ITER: one partial-product or trial-subtract step per cycle. When the counter reaches 0, write RC, busy=0, go to DONE.
  - DONE: done=1 for this cycle only. start is also accepted here, handled exactly as in IDLE (back-to-back ops); otherwise return to IDLE.
- Latency, measured from the accepting edge N:
  - single-cycle op: done high in cycle N+1.
  - MUL/DIV: done high in cycle N+WIDTH+1.
- start while busy: ignored; no queueing.
- RC holds its value from the done cycle until the next op writes it.
- Operand changes on RA/RB during ITER have no effect.
- DIV with RB==0: no iteration; completes with single-cycle latency, LO = all ones, HI = RA, div_zero=1.
- div_zero clears on the next accepted start.
- clear during ITER aborts the operation; no done pulse is produced.

Optional Feature:
- SEQ_ALU_SIGNED_MULDIV_EN defined:
  - MUL and DIV treat operands as two's complement. Magnitudes are iterated; an extra sign-fix cycle follows ITER, so MUL/DIV latency becomes WIDTH+2.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - div_zero case: LO = all ones, HI = RA, unchanged.
  - Most-negative / -1 yields LO = most-negative, HI = 0.
- Not defined: MUL/DIV are unsigned, with latency WIDTH+1.
- All other ops are identical either way.

Test Plan:
- Reset, then add RA=0x7FFFFFFF, RB=1 -> done at N+1, RC=0x0000_0000_8000_0000, busy never high.
- mul RA=0xFFFFFFFF, RB=2 (unsigned build) -> busy for 32 cycles, done at N+33, RC=0x0000_0001_FFFF_FFFE. In the signed build: RC=0xFFFF_FFFF_FFFF_FFFE at N+34.
- div RA=100, RB=7 -> done at N+33, LO=14, HI=2. Then div RA=5, RB=0 -> done at N+1, LO=0xFFFFFFFF, HI=5, div_zero=1; the next add clears div_zero.
- Shift/rotate: ror RA=0x00000001, RB=1 -> LO=0x80000000. shl RA=1, RB=33 (amount 1) -> LO=2. not RB=0 -> LO=0xFFFFFFFF.
- Handshake: start mul, pulse start with add during ITER -> ignored, product correct. Assert start with sub in the DONE cycle -> sub result 1 cycle later.
- clear asserted at cycle N+10 of a div -> next cycle RC=0, busy=0, done=0, and no done pulse follows; a subsequent div completes correctly.
